// File: rtl/rgb_frame_gen_pkg.sv
// rtl/rgb_frame_gen_pkg.sv - shared types, default frame size and colour-bar table for rgb_frame_gen
package rgb_frame_gen_pkg;

   localparam int img_width_bmp  = 400;
   localparam int img_height_bmp = 300;

   typedef enum logic [1:0] {PAT_SOLID, PAT_BARS, PAT_RAMP, PAT_CHECK} pattern_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_VBLANK} gen_state_e;

   localparam logic [0:7][23:0] BAR_COLOR = {
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

endpackage

// File: rtl/rgb_pattern_lut.sv
// rtl/rgb_pattern_lut.sv - registered test-pattern mux, one cycle from pixel coordinate to RGB
module rgb_pattern_lut
   import rgb_frame_gen_pkg::*;
#(
   parameter int CHK_SHIFT = 3
) (
   input  logic        pixclk,
   input  logic        reset,
   input  logic        en,
   input  logic [1:0]  sel,
   input  logic [11:0] x,
   input  logic [11:0] y,
   input  logic [2:0]  bar_idx,
   input  logic [23:0] solid,
   output logic [23:0] rgb
);

   logic [23:0] pix;

   always_comb begin
      pix = '0;
      case (pattern_e'(sel))
         PAT_SOLID: pix = solid;
         PAT_BARS:  pix = BAR_COLOR[bar_idx];
         PAT_RAMP:  pix = {x[7:0], y[7:0], 8'(x + y)};
         PAT_CHECK: pix = (x[CHK_SHIFT] ^ y[CHK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
         default:   pix = '0;
      endcase
   end

   always_ff @(posedge pixclk) begin
      if (!reset || !en)
         rgb <= '0;
      else
         rgb <= pix;
   end

endmodule

// File: rtl/rgb_frame_gen.sv
// rtl/rgb_frame_gen.sv - raster RGB frame source with blanking and test patterns
// Optional per-line pixel stalls are built when RGB_FRAME_GEN_STALL_EN is defined.
module rgb_frame_gen
   import rgb_frame_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = img_width_bmp,
   parameter int IMG_HEIGHT = img_height_bmp,
   parameter int H_BLANK    = 16,
   parameter int V_BLANK    = 4,
   parameter int BAR_W      = IMG_WIDTH / 8,
   parameter int CHK_SHIFT  = 3
`ifdef RGB_FRAME_GEN_STALL_EN
   , parameter int STALL_PERIOD = 8
`endif
) (
   input  logic        pixclk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   input  logic [7:0]  num_frames,
   output logic        valid,
   output logic [7:0]  oRed,
   output logic [7:0]  oGreen,
   output logic [7:0]  oBlue,
   output logic [11:0] x_coord,
   output logic [11:0] y_coord,
   output logic        sof,
   output logic        eol,
   output logic        eof,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [11:0] LAST_X   = 12'(IMG_WIDTH - 1);
   localparam logic [11:0] LAST_Y   = 12'(IMG_HEIGHT - 1);
   localparam logic [11:0] HB_LAST  = 12'(H_BLANK > 0 ? H_BLANK - 1 : 0);
   localparam logic [11:0] VB_LAST  = 12'(V_BLANK - 1);
   localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

   gen_state_e  st, n_st;
   logic [11:0] cx, cy, n_x, n_y, cnt, n_cnt, bar_cnt, n_bar_cnt;
   logic [2:0]  bar_idx, n_bar_idx;
   logic [7:0]  frames_left, n_frames;
   logic [1:0]  sel_q, n_sel;
   logic [23:0] solid_q, n_solid, rgb;
   logic        n_valid, n_fd, line_start, step_x;

`ifdef RGB_FRAME_GEN_STALL_EN
   localparam logic [11:0] RUN_LAST = 12'(STALL_PERIOD - 2);
   logic        stalled, n_stall;
   logic [11:0] run_cnt, n_run;
`endif

   // Look-ahead: everything below describes the pixel emitted after the next edge,
   // so the pattern LUT and the coordinate/flag registers land in the same cycle.
   always_comb begin
      n_st       = st;
      n_x        = cx;
      n_y        = cy;
      n_cnt      = cnt;
      n_bar_idx  = bar_idx;
      n_bar_cnt  = bar_cnt;
      n_frames   = frames_left;
      n_sel      = sel_q;
      n_solid    = solid_q;
      n_valid    = 1'b0;
      n_fd       = 1'b0;
      line_start = 1'b0;
      step_x     = 1'b0;
`ifdef RGB_FRAME_GEN_STALL_EN
      n_stall    = 1'b0;
      n_run      = run_cnt;
`endif
      case (st)
         ST_IDLE: begin
            if (start && num_frames != 8'd0) begin
               n_st       = ST_ACTIVE;
               n_sel      = pattern_sel;
               n_solid    = solid_rgb;
               n_frames   = num_frames;
               n_y        = '0;
               line_start = 1'b1;
            end
         end
         ST_ACTIVE: begin
`ifdef RGB_FRAME_GEN_STALL_EN
            if (stalled)
               step_x = 1'b1;
            else if (cx != LAST_X && run_cnt == RUN_LAST)
               n_stall = 1'b1;
            else
`endif
            if (cx == LAST_X) begin
               if (cy != LAST_Y) begin
                  if (H_BLANK == 0) begin
                     n_y        = cy + 12'd1;
                     line_start = 1'b1;
                  end else begin
                     n_st  = ST_HBLANK;
                     n_cnt = '0;
                  end
               end else begin
                  n_st     = ST_VBLANK;
                  n_cnt    = '0;
                  n_fd     = 1'b1;
                  n_frames = frames_left - 8'd1;
               end
            end else begin
               step_x = 1'b1;
            end
         end
         ST_HBLANK: begin
            if (cnt == HB_LAST) begin
               n_st       = ST_ACTIVE;
               n_y        = cy + 12'd1;
               line_start = 1'b1;
            end else begin
               n_cnt = cnt + 12'd1;
            end
         end
         ST_VBLANK: begin
            if (cnt == VB_LAST) begin
               if (frames_left == 8'd0) begin
                  n_st = ST_IDLE;
               end else begin
                  n_st       = ST_ACTIVE;
                  n_y        = '0;
                  line_start = 1'b1;
               end
            end else begin
               n_cnt = cnt + 12'd1;
            end
         end
         default: n_st = ST_IDLE;
      endcase

      if (line_start) begin
         n_x       = '0;
         n_bar_idx = '0;
         n_bar_cnt = '0;
         n_valid   = 1'b1;
`ifdef RGB_FRAME_GEN_STALL_EN
         n_run     = '0;
`endif
      end else if (step_x) begin
         n_x     = cx + 12'd1;
         n_valid = 1'b1;
         if (bar_cnt == BAR_LAST) begin
            n_bar_cnt = '0;
            if (bar_idx != 3'd7)
               n_bar_idx = bar_idx + 3'd1;
         end else begin
            n_bar_cnt = bar_cnt + 12'd1;
         end
`ifdef RGB_FRAME_GEN_STALL_EN
         n_run = stalled ? 12'd0 : run_cnt + 12'd1;
`endif
      end
   end

   always_ff @(posedge pixclk) begin
      if (!reset) begin
         st          <= ST_IDLE;
         cx          <= '0;
         cy          <= '0;
         cnt         <= '0;
         bar_idx     <= '0;
         bar_cnt     <= '0;
         frames_left <= '0;
         sel_q       <= '0;
         solid_q     <= '0;
         valid       <= 1'b0;
         x_coord     <= '0;
         y_coord     <= '0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         eof         <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         st          <= n_st;
         cx          <= n_x;
         cy          <= n_y;
         cnt         <= n_cnt;
         bar_idx     <= n_bar_idx;
         bar_cnt     <= n_bar_cnt;
         frames_left <= n_frames;
         sel_q       <= n_sel;
         solid_q     <= n_solid;
         valid       <= n_valid;
         x_coord     <= n_valid ? n_x : 12'd0;
         y_coord     <= n_valid ? n_y : 12'd0;
         sof         <= n_valid && n_x == 12'd0 && n_y == 12'd0;
         eol         <= n_valid && n_x == LAST_X;
         eof         <= n_valid && n_x == LAST_X && n_y == LAST_Y;
         busy        <= n_st != ST_IDLE;
         frame_done  <= n_fd;
      end
   end

`ifdef RGB_FRAME_GEN_STALL_EN
   always_ff @(posedge pixclk) begin
      if (!reset) begin
         stalled <= 1'b0;
         run_cnt <= '0;
      end else begin
         stalled <= n_stall;
         run_cnt <= n_run;
      end
   end
`endif

   rgb_pattern_lut #(
      .CHK_SHIFT (CHK_SHIFT)
   ) u_lut (
      .pixclk  (pixclk),
      .reset   (reset),
      .en      (n_valid),
      .sel     (n_sel),
      .x       (n_x),
      .y       (n_y),
      .bar_idx (n_bar_idx),
      .solid   (n_solid),
      .rgb     (rgb)
   );

   assign {oRed, oGreen, oBlue} = rgb;

endmodule
